updown_counter: RTL
===================

# updown_counter

Parametrised up/down counter that generalises the team's basic enable-only counter. It adds direction control, a programmable terminal value, synchronous load and clear, wrap or saturate mode, and a boundary-event pulse. It is used by the SRAM control and BIST logic as an address and cycle counter wherever a plain free-running counter is not enough.

## Interface
- WIDTH, 12, counter width in bits (≥ 2)
- MAX, 2**WIDTH-1, terminal value; count range is 0..MAX; must satisfy 1 ≤ MAX ≤ 2**WIDTH-1
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  count enable; one step per rising edge while high
- up  input  1  direction: 1 = increment, 0 = decrement
- clear  input  1  synchronous clear of value and ovf
- load  input  1  synchronous load of load_value
- load_value  input  WIDTH  value to load
- value  output  WIDTH  current count (registered)
- limit  output  1  registered one-cycle pulse on a boundary event
- ovf  output  1  sticky boundary-event flag (see Configuration)

## Operation
- Per-edge priority: clear > load > en. Lower-priority inputs are ignored in a cycle where a higher one is active.
- clear: value ← 0, ovf ← 0, limit ← 0.
- load: value ← min(load_value, MAX); limit ← 0; ovf unchanged.
- en && up:
  - value < MAX: value ← value+1.
  - value == MAX: boundary event. value ← 0 when SATURATE=0; holds MAX when SATURATE=1.
- en && !up:
  - value > 0: value ← value−1.
  - value == 0: boundary event. value ← MAX when SATURATE=0; holds 0 when SATURATE=1.
- Boundary event: limit ← 1 for exactly that cycle; ovf ← 1. Otherwise limit ← 0.
- en low (and no clear/load): value holds, limit ← 0.
- Repeated boundary attempts in saturate mode raise limit on every enabled edge.
- Arithmetic: the comparison against MAX uses full WIDTH, with no internal wider accumulator. value never exceeds MAX.
- Direction may change on any cycle; the next step uses the new up.

## Timing
- Reset: value = 0, limit = 0, ovf = 0.
  - Asynchronous: takes effect immediately on rst rising, independent of clk.
  - Release is sampled at the next rising edge.
- Latency: an en/load/clear sampled at edge N is visible on value/limit/ovf after edge N. There is no combinational path from inputs to outputs.
- After rst deassertion with en held high for k edges (k ≤ MAX), value = k.
- Reset asserted mid-count discards the count; counting restarts from 0.
- Simultaneous load and en: load wins, no step is taken that cycle.
- Simultaneous clear and boundary event: clear wins, limit = 0, ovf = 0.

## Configuration
- UPDOWN_COUNTER_OVF_EN:
  - Defined: ovf is a sticky register, set on any boundary event and cleared only by rst or clear.
  - Undefined: no ovf register is built and ovf is tied to 0. limit is unaffected.

## Test plan
- Reset/hold (WIDTH=12, defaults): rst high 16 edges, then low 16 edges with en=0 -> value=0, limit=0, ovf=0. Then en=1, up=1 for 16 edges -> value=16; 16 more edges -> value=32.
- Wrap up (MAX=9, SATURATE=0): load 8, then en=1, up=1 for 3 edges -> value 9, 0, 1. limit is high only after the edge producing 0; ovf=1 thereafter (with macro).
- Saturate down (MAX=9, SATURATE=1): load 1, en=1, up=0 for 4 edges -> value 0, 0, 0, 0. limit stays high after edges 2–4; clear -> value=0, ovf=0.
- Priority/clamp (MAX=9): load_value=15, load=1, en=1 -> value=9, no step. clear=1 with load=1 -> value=0.
- Async reset mid-count: count to 5, assert rst between edges -> value=0 before the next edge. After release, en=1 for 3 edges -> value=3.
- Macro off: repeat the wrap test without UPDOWN_COUNTER_OVF_EN -> limit identical, ovf constant 0.

Source files
------------

// File: rtl/updown_counter.sv
// updown_counter -- parametrised up/down counter with terminal value,
// synchronous clear/load, wrap or saturate mode and boundary-event flags.
//
// Parameters:
//   WIDTH    counter width in bits (>= 2)
//   MAX      terminal value, count range 0..MAX (1 <= MAX <= 2**WIDTH-1)
//   SATURATE 0 = wrap at boundaries, 1 = hold at boundaries
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         count enable, one step per edge
//   up         direction, 1 = increment, 0 = decrement
//   clear      synchronous clear of value, limit and ovf (highest priority)
//   load       synchronous load of min(load_value, MAX)
//   load_value value to load
//   value      registered count
//   limit      registered one-cycle pulse on a boundary event
//   ovf        sticky boundary-event flag
//
// Build option:
//   UPDOWN_COUNTER_OVF_EN  when defined, ovf is a sticky register set on any
//                          boundary event and cleared by rst or clear;
//                          otherwise ovf is tied to 0.

module updown_counter #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned MAX      = (1 << WIDTH) - 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             limit,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             limit_q;
  logic             boundary;

  // Next-state: clear > load > en. A boundary event is only possible on an
  // enabled step, so it is never raised in a clear or load cycle.
  always_comb begin
    value_d  = value_q;
    boundary = 1'b0;
    if (clear) begin
      value_d = '0;
    end else if (load) begin
      value_d = (load_value > MAX_V) ? MAX_V : load_value;
    end else if (en) begin
      if (up) begin
        if (value_q == MAX_V) begin
          boundary = 1'b1;
          value_d  = (SATURATE != 0) ? MAX_V : '0;
        end else begin
          value_d = value_q + 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          boundary = 1'b1;
          value_d  = (SATURATE != 0) ? '0 : MAX_V;
        end else begin
          value_d = value_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      limit_q <= 1'b0;
    end else begin
      value_q <= value_d;
      limit_q <= boundary;
    end
  end

  assign value = value_q;
  assign limit = limit_q;

`ifdef UPDOWN_COUNTER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
    end else if (boundary) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
